rs_age_select: RTL and testbench
================================

# rs_age_select

Parametrised reservation station with oldest-first dispatch, multi-channel result broadcast (CDB) wakeup, and a backpressured dispatch port. It sits between the issue stage and a single execution unit (ALU). It buffers up to DEPTH renamed instructions and captures operand values from NUM_CDB broadcast channels. It dispatches the oldest ready entry into a registered output slot that holds until the unit accepts it.

## Interface
- DEPTH, 16: number of entries (≥2).
- DATA_W, 32: operand/result/imm/PC width.
- ROB_W, 4: ROB index width. Index 0 is reserved and means "no dependency".
- NUM_CDB, 2: broadcast channels (≥1).
- OPTYPE_W, 7: op-type field width.
- OPENUM_W, 6: op-enum field width.

- clk_in  in  1  clock. One clock domain.
- rst_in  in  1  reset. Synchronous, active-high.
- rdy_in  in  1  global enable. When low, all state is held and all inputs are ignored.
- clr_in  in  1  misprediction flush. Synchronous; same effect as reset.
- issue_valid  in  1  allocate an entry this cycle.
- issue_rob_index  in  ROB_W  destination ROB tag.
- issue_op_type  in  OPTYPE_W
- issue_op  in  OPENUM_W
- issue_rs1_val, issue_rs2_val  in  DATA_W  operand values. Valid only when the matching depend is 0.
- issue_rs1_depend, issue_rs2_depend  in  ROB_W  producer tag; 0 means ready.
- issue_imm, issue_pc  in  DATA_W
- cdb_valid  in  NUM_CDB  per-channel broadcast valid.
- cdb_rob_index  in  NUM_CDB*ROB_W  channel c occupies bits [c*ROB_W +: ROB_W].
- cdb_result  in  NUM_CDB*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- disp_ready  in  1  execution unit accepts the output slot this cycle.
- disp_valid  out  1  output slot holds an instruction.
- disp_op, disp_op_type, disp_rs1, disp_rs2, disp_rob_index, disp_pc, disp_imm  out  matching widths.
- rs_full  out  1  registered; high when all DEPTH entries are busy.
- rs_free_count  out  clog2(DEPTH+1)  registered count of free entries.

## Operation
**Per-entry state:** busy, tags, values, imm, pc, op fields. An age matrix older[i][j] records that entry i was allocated before entry j.

**Allocation:**
- On issue_valid, take the lowest-index non-busy entry, chosen from the pre-edge state.
- On allocation of slot k: clear older[k][*]; set older[j][k] = busy[j] for every j.
- An entry freed by dispatch at the same edge cannot be reused until the next cycle.

**Issue-time bypass:**
- If issue_rsX_depend ≠ 0 and it matches a valid CDB channel in the same cycle, store that channel's result and tag 0.

**Wakeup:**
- For every busy entry, a tag matching a valid CDB channel captures the result and clears the tag.
- Wakeup is registered.
- If several channels carry the same tag, the lowest channel index wins.
- A CDB channel with tag 0 never matches.

**Select:**
- An entry is ready when it is busy and both tags are 0.
- Choose the ready entry i for which no other ready j has older[j][i]. This is exactly one entry.

**Fire:**
- Fire when some entry is ready and (!disp_valid || disp_ready).
- On fire, copy the selected entry into the output registers, set disp_valid, and clear the entry's busy bit.
- If disp_ready is high with no fire, clear disp_valid.
- While disp_valid && !disp_ready, all disp_* outputs are held stable.

**Occupancy:**
- rs_free_count_next = rs_free_count + fire − alloc.
- rs_full_next = (rs_free_count_next == 0).

**Protocol and flush:**
- issue_valid while rs_full is a protocol violation. No entry is written and the counters are unchanged.
- rst_in or clr_in: all busy bits = 0, age matrix = 0, disp_valid = 0, all disp_* = 0, rs_full = 0, rs_free_count = DEPTH.
- A flush takes priority over any simultaneous issue, CDB or dispatch.

## Timing
- Reset values: disp_valid 0, disp_* 0, rs_full 0, rs_free_count DEPTH.
- Issue with both operands ready sampled at edge E: disp_valid is high after edge E+1 at the earliest (2-edge latency).
- Last operand woken by a CDB broadcast at edge E: disp_valid after E+1, with disp_rsX equal to that cdb_result.
- Issue-time bypass gives the same latency as an issue with ready operands.
- Sustained throughput is 1 dispatch per cycle while disp_ready stays high.
- Simultaneous issue, CDB and fire in one cycle are all honoured. An entry dispatched at edge E is not woken at E; it was already ready.
- rdy_in low: no register changes. Upstream must not broadcast on the CDB while rdy_in is low.
- Flush mid-stall (disp_valid high, disp_ready low): disp_valid is 0 after the flush edge.

## Test plan
- **Reset and fill.** Reset, then issue 16 ready ADDs (rob 1..15, 1) with disp_ready=0 → rs_free_count goes 16→15 after the first edge. rs_full rises once 16 entries are held; the output slot takes one entry, so this happens on the 17th issue. disp_rob_index stays 1 and is held stable.
- **Age order.** Issue rob 3 (depend rs1=5), then rob 4 (ready), then rob 6 (ready). Broadcast CDB0 tag 5 = 0x1234. With disp_ready=1, dispatch order is 4, 6, 3, and disp_rs1=0x1234 for rob 3.
- **Issue bypass and dual CDB.** Issue rob 7 with depends 2 and 9 while CDB0={2,0xAA} and CDB1={9,0xBB} in the same cycle → disp_valid after the next edge with rs1=0xAA, rs2=0xBB.
- **Backpressure.** Hold disp_ready=0 for 5 cycles with 3 ready entries → disp_* are unchanged for those cycles. Raise disp_ready → one dispatch per cycle, 3 cycles total.
- **Flush.** Issue 4 entries, with disp_valid high and a stall. Pulse clr_in at the same edge as issue_valid and a CDB broadcast → after the edge, disp_valid=0, rs_free_count=16, and no later dispatch occurs.
- **rdy_in freeze.** Drop rdy_in for 3 cycles with a ready entry and disp_ready=1 → no dispatch and counts are unchanged. Dispatch occurs on the first edge after rdy_in returns high.

Source files
------------

// File: rtl/rs_age_select.sv
// Reservation station with age-matrix oldest-first select, multi-channel
// CDB wakeup and a registered, backpressured dispatch slot.
module rs_age_select #(
  parameter int DEPTH    = 16,
  parameter int DATA_W   = 32,
  parameter int ROB_W    = 4,
  parameter int NUM_CDB  = 2,
  parameter int OPTYPE_W = 7,
  parameter int OPENUM_W = 6,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        clr_in,
  input  logic                        issue_valid,
  input  logic [ROB_W-1:0]            issue_rob_index,
  input  logic [OPTYPE_W-1:0]         issue_op_type,
  input  logic [OPENUM_W-1:0]         issue_op,
  input  logic [DATA_W-1:0]           issue_rs1_val,
  input  logic [DATA_W-1:0]           issue_rs2_val,
  input  logic [ROB_W-1:0]            issue_rs1_depend,
  input  logic [ROB_W-1:0]            issue_rs2_depend,
  input  logic [DATA_W-1:0]           issue_imm,
  input  logic [DATA_W-1:0]           issue_pc,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]    cdb_rob_index,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_result,
  input  logic                        disp_ready,
  output logic                        disp_valid,
  output logic [OPENUM_W-1:0]         disp_op,
  output logic [OPTYPE_W-1:0]         disp_op_type,
  output logic [DATA_W-1:0]           disp_rs1,
  output logic [DATA_W-1:0]           disp_rs2,
  output logic [ROB_W-1:0]            disp_rob_index,
  output logic [DATA_W-1:0]           disp_pc,
  output logic [DATA_W-1:0]           disp_imm,
  output logic                        rs_full,
  output logic [CNT_W-1:0]            rs_free_count
);

  // Returns {hit, result}; the lowest channel wins and tag 0 never hits.
  function automatic logic [DATA_W:0] cdb_match(
    input logic [ROB_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        vld,
    input logic [NUM_CDB*ROB_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] res
  );
    logic [DATA_W:0] m;
    m = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (vld[c] && tag != '0 && tags[c*ROB_W +: ROB_W] == tag)
        m = {1'b1, res[c*DATA_W +: DATA_W]};
    end
    return m;
  endfunction

  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DEPTH-1:0]    older_q [DEPTH];
  logic [DEPTH-1:0]    older_d [DEPTH];
  logic [ROB_W-1:0]    t1_q [DEPTH];
  logic [ROB_W-1:0]    t1_d [DEPTH];
  logic [ROB_W-1:0]    t2_q [DEPTH];
  logic [ROB_W-1:0]    t2_d [DEPTH];
  logic [DATA_W-1:0]   v1_q [DEPTH];
  logic [DATA_W-1:0]   v1_d [DEPTH];
  logic [DATA_W-1:0]   v2_q [DEPTH];
  logic [DATA_W-1:0]   v2_d [DEPTH];
  logic [DATA_W-1:0]   imm_q [DEPTH];
  logic [DATA_W-1:0]   imm_d [DEPTH];
  logic [DATA_W-1:0]   pc_q [DEPTH];
  logic [DATA_W-1:0]   pc_d [DEPTH];
  logic [ROB_W-1:0]    rob_q [DEPTH];
  logic [ROB_W-1:0]    rob_d [DEPTH];
  logic [OPTYPE_W-1:0] ot_q [DEPTH];
  logic [OPTYPE_W-1:0] ot_d [DEPTH];
  logic [OPENUM_W-1:0] op_q [DEPTH];
  logic [OPENUM_W-1:0] op_d [DEPTH];

  logic                dv_q, dv_d;
  logic [OPENUM_W-1:0] dop_q, dop_d;
  logic [OPTYPE_W-1:0] dot_q, dot_d;
  logic [DATA_W-1:0]   drs1_q, drs1_d;
  logic [DATA_W-1:0]   drs2_q, drs2_d;
  logic [ROB_W-1:0]    drob_q, drob_d;
  logic [DATA_W-1:0]   dpc_q, dpc_d;
  logic [DATA_W-1:0]   dimm_q, dimm_d;
  logic                full_q, full_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [DEPTH-1:0]    ready, sel, alloc_oh, col;
  logic                found, fire, alloc, flush;
  logic [DATA_W:0]     im1, im2, wm1, wm2;
  logic [ROB_W-1:0]    i_t1, i_t2;
  logic [DATA_W-1:0]   i_v1, i_v2;

  always_comb begin
    ready    = '0;
    sel      = '0;
    alloc_oh = '0;
    col      = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      ready[i] = busy_q[i] && t1_q[i] == '0 && t2_q[i] == '0;
    // An entry is selected when no other ready entry is older than it.
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++)
        col[j] = older_q[j][i];
      sel[i] = ready[i] && ~|(col & ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_q[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign fire  = |ready && (!dv_q || disp_ready);
  assign alloc = issue_valid && !full_q && found;
  assign flush = rst_in || (rdy_in && clr_in);

  always_comb begin
    im1  = cdb_match(issue_rs1_depend, cdb_valid, cdb_rob_index, cdb_result);
    im2  = cdb_match(issue_rs2_depend, cdb_valid, cdb_rob_index, cdb_result);
    i_t1 = im1[DATA_W] ? '0 : issue_rs1_depend;
    i_t2 = im2[DATA_W] ? '0 : issue_rs2_depend;
    i_v1 = im1[DATA_W] ? im1[DATA_W-1:0] : issue_rs1_val;
    i_v2 = im2[DATA_W] ? im2[DATA_W-1:0] : issue_rs2_val;
  end

  always_comb begin
    busy_d  = busy_q;
    older_d = older_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    rob_d   = rob_q;
    ot_d    = ot_q;
    op_d    = op_q;
    dv_d    = dv_q;
    dop_d   = dop_q;
    dot_d   = dot_q;
    drs1_d  = drs1_q;
    drs2_d  = drs2_q;
    drob_d  = drob_q;
    dpc_d   = dpc_q;
    dimm_d  = dimm_q;
    wm1     = '0;
    wm2     = '0;

    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i]) begin
        wm1 = cdb_match(t1_q[i], cdb_valid, cdb_rob_index, cdb_result);
        wm2 = cdb_match(t2_q[i], cdb_valid, cdb_rob_index, cdb_result);
        if (wm1[DATA_W]) begin
          t1_d[i] = '0;
          v1_d[i] = wm1[DATA_W-1:0];
        end
        if (wm2[DATA_W]) begin
          t2_d[i] = '0;
          v2_d[i] = wm2[DATA_W-1:0];
        end
      end
    end

    if (fire) begin
      dv_d   = 1'b1;
      busy_d = busy_d & ~sel;
      for (int i = 0; i < DEPTH; i++) begin
        if (sel[i]) begin
          dop_d  = op_q[i];
          dot_d  = ot_q[i];
          drs1_d = v1_q[i];
          drs2_d = v2_q[i];
          drob_d = rob_q[i];
          dpc_d  = pc_q[i];
          dimm_d = imm_q[i];
        end
      end
    end else if (disp_ready) begin
      dv_d = 1'b0;
    end

    if (alloc) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc_oh[k]) begin
          busy_d[k]  = 1'b1;
          older_d[k] = '0;
          for (int j = 0; j < DEPTH; j++)
            older_d[j][k] = busy_q[j];
          t1_d[k]  = i_t1;
          t2_d[k]  = i_t2;
          v1_d[k]  = i_v1;
          v2_d[k]  = i_v2;
          imm_d[k] = issue_imm;
          pc_d[k]  = issue_pc;
          rob_d[k] = issue_rob_index;
          ot_d[k]  = issue_op_type;
          op_d[k]  = issue_op;
        end
      end
    end

    cnt_d = cnt_q;
    if (fire && !alloc)
      cnt_d = cnt_q + CNT_W'(1);
    else if (!fire && alloc)
      cnt_d = cnt_q - CNT_W'(1);
    full_d = (cnt_d == '0);
  end

  always_ff @(posedge clk_in) begin
    if (flush) begin
      busy_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        older_q[i] <= '0;
      dv_q   <= 1'b0;
      dop_q  <= '0;
      dot_q  <= '0;
      drs1_q <= '0;
      drs2_q <= '0;
      drob_q <= '0;
      dpc_q  <= '0;
      dimm_q <= '0;
      full_q <= 1'b0;
      cnt_q  <= CNT_W'(DEPTH);
    end else if (rdy_in) begin
      busy_q  <= busy_d;
      older_q <= older_d;
      dv_q    <= dv_d;
      dop_q   <= dop_d;
      dot_q   <= dot_d;
      drs1_q  <= drs1_d;
      drs2_q  <= drs2_d;
      drob_q  <= drob_d;
      dpc_q   <= dpc_d;
      dimm_q  <= dimm_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload is qualified by busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      t1_q  <= t1_d;
      t2_q  <= t2_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      imm_q <= imm_d;
      pc_q  <= pc_d;
      rob_q <= rob_d;
      ot_q  <= ot_d;
      op_q  <= op_d;
    end
  end

  assign disp_valid     = dv_q;
  assign disp_op        = dop_q;
  assign disp_op_type   = dot_q;
  assign disp_rs1       = drs1_q;
  assign disp_rs2       = drs2_q;
  assign disp_rob_index = drob_q;
  assign disp_pc        = dpc_q;
  assign disp_imm       = dimm_q;
  assign rs_full        = full_q;
  assign rs_free_count  = cnt_q;

endmodule

// File: tb/tb_rs_age_select.sv
// Scoreboard bench for rs_age_select: stimulus queues expected dispatches,
// a negedge monitor pops and compares on every accepted dispatch.
module tb_rs_age_select;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic        issue_valid;
  logic [3:0]  issue_rob_index;
  logic [6:0]  issue_op_type;
  logic [5:0]  issue_op;
  logic [31:0] issue_rs1_val, issue_rs2_val;
  logic [3:0]  issue_rs1_depend, issue_rs2_depend;
  logic [31:0] issue_imm, issue_pc;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_index;
  logic [63:0] cdb_result;
  logic        disp_ready;
  logic        disp_valid;
  logic [5:0]  disp_op;
  logic [6:0]  disp_op_type;
  logic [31:0] disp_rs1, disp_rs2, disp_pc, disp_imm;
  logic [3:0]  disp_rob_index;
  logic        rs_full;
  logic [4:0]  rs_free_count;

  rs_age_select dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .issue_valid(issue_valid), .issue_rob_index(issue_rob_index),
    .issue_op_type(issue_op_type), .issue_op(issue_op),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
    .issue_rs1_depend(issue_rs1_depend),
    .issue_rs2_depend(issue_rs2_depend),
    .issue_imm(issue_imm), .issue_pc(issue_pc),
    .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index),
    .cdb_result(cdb_result), .disp_ready(disp_ready),
    .disp_valid(disp_valid), .disp_op(disp_op),
    .disp_op_type(disp_op_type), .disp_rs1(disp_rs1),
    .disp_rs2(disp_rs2), .disp_rob_index(disp_rob_index),
    .disp_pc(disp_pc), .disp_imm(disp_imm),
    .rs_full(rs_full), .rs_free_count(rs_free_count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] pc_of(input logic [3:0] r);
    return 32'h1000 + {26'b0, r, 2'b0};
  endfunction

  function automatic logic [31:0] ops_of(input logic [3:0] r);
    return {19'b0, 7'h30 | {3'b0, r}, {2'b0, r}};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [3:0] rob, input logic [31:0] r1,
                      input logic [31:0] r2);
    exp_t e;
    e.rob = rob;
    e.rs1 = r1;
    e.rs2 = r2;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] rob, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [3:0] d1,
                       input logic [3:0] d2);
    issue_valid      = 1'b1;
    issue_rob_index  = rob;
    issue_rs1_val    = v1;
    issue_rs2_val    = v2;
    issue_rs1_depend = d1;
    issue_rs2_depend = d2;
    issue_pc         = pc_of(rob);
    issue_imm        = pc_of(rob) ^ 32'h0000_FFFF;
    issue_op         = {2'b0, rob};
    issue_op_type    = 7'h30 | {3'b0, rob};
    tick;
    issue_valid = 1'b0;
    cdb_valid   = 2'b00;
  endtask

  task automatic cdb_tick(input logic [1:0] v, input logic [3:0] t0,
                          input logic [31:0] r0, input logic [3:0] t1,
                          input logic [31:0] r1);
    cdb_valid     = v;
    cdb_rob_index = {t1, t0};
    cdb_result    = {r1, r0};
    tick;
    cdb_valid = 2'b00;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d left, expected 0", sb.size());
    end
  endtask

  // Monitor: a dispatch is accepted at the next posedge when these hold.
  always @(negedge clk_in) begin
    if (!rst_in && rdy_in && !clr_in && disp_valid && disp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dispatch: got rob %0d expected none",
                 disp_rob_index);
      end else begin
        mon_e = sb.pop_front();
        check("disp_rob", 32'(disp_rob_index), 32'(mon_e.rob));
        check("disp_rs1", disp_rs1, mon_e.rs1);
        check("disp_rs2", disp_rs2, mon_e.rs2);
        check("disp_pc", disp_pc, pc_of(mon_e.rob));
        check("disp_imm", disp_imm, pc_of(mon_e.rob) ^ 32'h0000_FFFF);
        check("disp_ops", {19'b0, disp_op_type, disp_op},
              ops_of(mon_e.rob));
      end
    end
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0;
    issue_valid = 1'b0; issue_rob_index = '0;
    issue_op_type = '0; issue_op = '0;
    issue_rs1_val = '0; issue_rs2_val = '0;
    issue_rs1_depend = '0; issue_rs2_depend = '0;
    issue_imm = '0; issue_pc = '0;
    cdb_valid = '0; cdb_rob_index = '0; cdb_result = '0;
    disp_ready = 1'b0;
    tick;
    tick;
    check("rst_valid", 32'(disp_valid), 32'd0);
    check("rst_full", 32'(rs_full), 32'd0);
    check("rst_free", 32'(rs_free_count), 32'd16);
    check("rst_rob", 32'(disp_rob_index), 32'd0);
    rst_in = 1'b0;

    // Fill with 17 ready entries while the unit stalls.
    for (int i = 0; i < 17; i++) begin
      logic [3:0] r;
      r = 4'(i % 15 + 1);
      push(r, 32'(i), 32'(i + 100));
      issue(r, 32'(i), 32'(i + 100), 4'd0, 4'd0);
      if (i == 0) check("fill_free1", 32'(rs_free_count), 32'd15);
      if (i == 1) check("fill_valid", 32'(disp_valid), 32'd1);
      if (i == 15) begin
        check("fill_free16", 32'(rs_free_count), 32'd1);
        check("fill_notfull", 32'(rs_full), 32'd0);
      end
      if (i == 16) begin
        check("fill_free17", 32'(rs_free_count), 32'd0);
        check("fill_full", 32'(rs_full), 32'd1);
      end
    end
    issue(4'd9, 32'hDEAD, 32'hBEEF, 4'd0, 4'd0);
    check("overflow_free", 32'(rs_free_count), 32'd0);
    check("overflow_full", 32'(rs_full), 32'd1);
    tick;
    tick;
    check("stall_rob", 32'(disp_rob_index), 32'd1);
    check("stall_rs1", disp_rs1, 32'd0);
    disp_ready = 1'b1;
    drain(60);
    tick;
    check("fill_drained_valid", 32'(disp_valid), 32'd0);
    check("fill_drained_free", 32'(rs_free_count), 32'd16);

    // Age order: a later-woken older entry goes last.
    push(4'd4, 32'h44, 32'h404);
    push(4'd6, 32'h66, 32'h606);
    push(4'd3, 32'h1234, 32'h303);
    issue(4'd3, 32'h0, 32'h303, 4'd5, 4'd0);
    issue(4'd4, 32'h44, 32'h404, 4'd0, 4'd0);
    issue(4'd6, 32'h66, 32'h606, 4'd0, 4'd0);
    cdb_tick(2'b01, 4'd5, 32'h1234, 4'd0, 32'h0);
    drain(20);
    tick;
    check("age_free", 32'(rs_free_count), 32'd16);

    // Issue bypass, same-tag channel priority, tag 0 never matching.
    disp_ready = 1'b0;
    push(4'd7, 32'hAA, 32'hBB);
    push(4'd5, 32'h11, 32'h505);
    push(4'd6, 32'h55, 32'h66);
    cdb_valid = 2'b11;
    cdb_rob_index = {4'd9, 4'd2};
    cdb_result = {32'hBB, 32'hAA};
    issue(4'd7, 32'h0, 32'h0, 4'd2, 4'd9);
    check("byp_latency", 32'(disp_valid), 32'd0);
    issue(4'd5, 32'h0, 32'h505, 4'd3, 4'd0);
    check("byp_valid", 32'(disp_valid), 32'd1);
    check("byp_rs1", disp_rs1, 32'hAA);
    check("byp_rs2", disp_rs2, 32'hBB);
    cdb_valid = 2'b01;
    cdb_rob_index = {4'd0, 4'd0};
    cdb_result = {32'h0, 32'h99};
    issue(4'd6, 32'h55, 32'h66, 4'd0, 4'd0);
    cdb_tick(2'b11, 4'd3, 32'h11, 4'd3, 32'h22);
    cdb_tick(2'b11, 4'd0, 32'h77, 4'd0, 32'h88);
    disp_ready = 1'b1;
    drain(20);
    tick;

    // Backpressure: slot held for 5 cycles, then 3 dispatches in 3 cycles.
    disp_ready = 1'b0;
    push(4'd10, 32'hA0, 32'hA1);
    push(4'd11, 32'hB0, 32'hB1);
    push(4'd12, 32'hC0, 32'hC1);
    issue(4'd10, 32'hA0, 32'hA1, 4'd0, 4'd0);
    issue(4'd11, 32'hB0, 32'hB1, 4'd0, 4'd0);
    issue(4'd12, 32'hC0, 32'hC1, 4'd0, 4'd0);
    for (int c = 0; c < 5; c++) begin
      tick;
      check("bp_valid", 32'(disp_valid), 32'd1);
      check("bp_rob", 32'(disp_rob_index), 32'd10);
      check("bp_rs1", disp_rs1, 32'hA0);
      check("bp_pc", disp_pc, pc_of(4'd10));
    end
    disp_ready = 1'b1;
    tick;
    tick;
    tick;
    check("bp_throughput", 32'(sb.size()), 32'd0);
    check("bp_empty_valid", 32'(disp_valid), 32'd0);

    // Flush mid-stall with simultaneous issue and CDB.
    disp_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      issue(4'(i), 32'(i), 32'(i), 4'd0, 4'd0);
    check("fl_pre_valid", 32'(disp_valid), 32'd1);
    clr_in = 1'b1;
    cdb_valid = 2'b01;
    cdb_rob_index = {4'd0, 4'd3};
    cdb_result = {32'h0, 32'h33};
    issue(4'd8, 32'h8, 32'h8, 4'd0, 4'd0);
    clr_in = 1'b0;
    check("fl_valid", 32'(disp_valid), 32'd0);
    check("fl_free", 32'(rs_free_count), 32'd16);
    check("fl_full", 32'(rs_full), 32'd0);
    check("fl_rob", 32'(disp_rob_index), 32'd0);
    check("fl_rs1", disp_rs1, 32'd0);
    disp_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick;
    check("fl_no_dispatch", 32'(disp_valid), 32'd0);
    check("fl_free_after", 32'(rs_free_count), 32'd16);

    // rdy_in freeze.
    push(4'd13, 32'hD0, 32'hD1);
    issue(4'd13, 32'hD0, 32'hD1, 4'd0, 4'd0);
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      check("frz_valid", 32'(disp_valid), 32'd0);
      check("frz_free", 32'(rs_free_count), 32'd15);
    end
    rdy_in = 1'b1;
    tick;
    check("frz_release_valid", 32'(disp_valid), 32'd1);
    check("frz_release_rob", 32'(disp_rob_index), 32'd13);
    tick;
    check("frz_done_valid", 32'(disp_valid), 32'd0);
    check("frz_done_free", 32'(rs_free_count), 32'd16);

    tick;
    tick;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
